// File: rtl/rr_replay_log_decoder.sv
// Replay log decoder: splits packed log records (header + per-channel payload
// words) into per-channel transactions, lowest channel index first.
module rr_replay_log_decoder #(
  parameter int DATA_W    = 64,
  parameter int NCH       = 5,
  parameter int MAX_WORDS = 8,
  parameter logic [4*NCH-1:0] CH_WORDS = 20'h88211
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic [NCH-1:0]              out_valid,
  input  logic [NCH-1:0]              out_ready,
  output logic [MAX_WORDS*DATA_W-1:0] out_data,
  output logic [15:0]                 out_seq,
  output logic [31:0]                 rec_cnt,
  output logic                        seq_err,
  output logic                        hdr_err,
  output logic                        busy
);

  localparam int WC_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  function automatic logic [DATA_W-1:0] rsv_mask();
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_W; i++) m[i] = ((i >= NCH) && (i < 16)) || (i >= 32);
    return m;
  endfunction

  localparam logic [DATA_W-1:0] RSV_MASK = rsv_mask();

  function automatic logic [3:0] lowest(input logic [NCH-1:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) if (m[i]) r = 4'(i);
    return r;
  endfunction

  typedef enum logic [1:0] {HDR, PAYLOAD, EMIT} state_t;

  state_t            state, state_nxt;
  logic [NCH-1:0]    mask;
  logic [NCH-1:0]    mask_left;
  logic [NCH-1:0]    cur_onehot;
  logic [3:0]        cur;
  logic [3:0]        len_cur;
  logic [WC_W-1:0]   wcnt;
  logic [DATA_W-1:0] buffer [MAX_WORDS];
  logic [15:0]       exp_seq;
  logic [NCH-1:0]    bitmap;
  logic [15:0]       seq;
  logic              hdr_ok;
  logic              last_word;
  logic              accept;

  assign bitmap     = in_data[NCH-1:0];
  assign seq        = in_data[31:16];
  assign hdr_ok     = (bitmap != '0) && ((in_data & RSV_MASK) == '0);
  assign cur_onehot = NCH'(1) << cur;
  assign mask_left  = mask & ~cur_onehot;
  assign len_cur    = CH_WORDS[4*cur +: 4];
  assign last_word  = (32'(wcnt) + 32'd1 == 32'(len_cur));
  assign accept     = |(out_ready & cur_onehot);

  always_ff @(posedge clk) begin
    if (rst) state <= HDR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = '0;
    busy      = 1'b1;
    case (state)
      HDR: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && hdr_ok) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_word) state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = cur_onehot;
        if (accept) state_nxt = (mask_left == '0) ? HDR : PAYLOAD;
      end
      default: state_nxt = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask    <= '0;
      cur     <= '0;
      wcnt    <= '0;
      out_seq <= '0;
      exp_seq <= '0;
      rec_cnt <= '0;
      seq_err <= 1'b0;
      hdr_err <= 1'b0;
      for (int k = 0; k < MAX_WORDS; k++) buffer[k] <= '0;
    end else begin
      case (state)
        HDR: begin
          if (in_valid) begin
            if (!hdr_ok) begin
              hdr_err <= 1'b1;
            end else begin
              mask    <= bitmap;
              out_seq <= seq;
              if (seq != exp_seq) seq_err <= 1'b1;
              exp_seq <= seq + 16'd1;
              cur     <= lowest(bitmap);
              wcnt    <= '0;
              for (int k = 0; k < MAX_WORDS; k++) buffer[k] <= '0;
            end
          end
        end
        PAYLOAD: begin
          if (in_valid) begin
            buffer[wcnt] <= in_data;
            wcnt         <= wcnt + 1'b1;
          end
        end
        EMIT: begin
          if (accept) begin
            mask <= mask_left;
            if (mask_left != '0) begin
              cur  <= lowest(mask_left);
              wcnt <= '0;
              for (int k = 0; k < MAX_WORDS; k++) buffer[k] <= '0;
            end else begin
              rec_cnt <= rec_cnt + 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Payload is only presented while a channel is being emitted.
  for (genvar k = 0; k < MAX_WORDS; k++) begin : g_out
    assign out_data[k*DATA_W +: DATA_W] = (state == EMIT) ? buffer[k] : '0;
  end

endmodule
